control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. It drives every control input of `datapath` (mux select, immediate, accumulator and register-file write enables, register address, ALU and shifter selects, output enable) from a 32-byte internal program memory. It consumes the datapath's `zero`/`positive` status for conditional jumps. The program memory is loaded through a byte-write port while the core is idle.

---
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit processor.
// Drives the datapath controls from a 32-byte program memory loaded through a byte-write port.
module control_unit #(
  parameter int unsigned PM_DEPTH = 32
) (
  input  logic       clk_ctrl,
  input  logic       rst_ctrl,
  input  logic       start_ctrl,
  input  logic       prog_we_ctrl,
  input  logic [4:0] prog_addr_ctrl,
  input  logic [7:0] prog_data_ctrl,
  input  logic       zero_ctrl,
  input  logic       positive_ctrl,
  output logic [1:0] muxsel_ctrl,
  output logic [7:0] imm_ctrl,
  output logic       accwr_ctrl,
  output logic [2:0] rfaddr_ctrl,
  output logic       rfwr_ctrl,
  output logic [2:0] alusel_ctrl,
  output logic [1:0] shiftsel_ctrl,
  output logic       outen_ctrl,
  output logic       halted_ctrl
);

  localparam int unsigned PcW = $clog2(PM_DEPTH);

  localparam logic [3:0] OpLda  = 4'b0001;
  localparam logic [3:0] OpSta  = 4'b0010;
  localparam logic [3:0] OpLdi  = 4'b0011;
  localparam logic [3:0] OpIn   = 4'b0100;
  localparam logic [3:0] OpOut  = 4'b0101;
  localparam logic [3:0] OpJmp  = 4'b0110;
  localparam logic [3:0] OpJz   = 4'b0111;
  localparam logic [3:0] OpJp   = 4'b1000;
  localparam logic [3:0] OpShm  = 4'b1001;
  localparam logic [3:0] OpHalt = 4'b1010;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StOperand,
    StExecute,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [PcW-1:0]   pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       opr_q, opr_d;
  logic [1:0]       shm_q, shm_d;
  logic             fz_q, fz_d;
  logic             fp_q, fp_d;

  logic [7:0]       pm_mem [PM_DEPTH];
  logic [7:0]       pm_rdata;
  logic [PcW-1:0]   pc_inc;
  logic             is_alu;
  logic [3:0]       opcode;
  logic             two_byte;

  // Write port is not reset; a read on the write edge sees the old byte.
  always_ff @(posedge clk_ctrl) begin
    if (prog_we_ctrl) begin
      pm_mem[prog_addr_ctrl] <= prog_data_ctrl;
    end
  end

  assign pm_rdata = pm_mem[pc_q];
  assign pc_inc   = pc_q + PcW'(1);
  assign is_alu   = ir_q[7];
  assign opcode   = ir_q[6:3];
  assign two_byte = !is_alu &&
                    (opcode == OpLdi || opcode == OpJmp || opcode == OpJz || opcode == OpJp);

  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      shm_q   <= '0;
      fz_q    <= 1'b0;
      fp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      shm_q   <= shm_d;
      fz_q    <= fz_d;
      fp_q    <= fp_d;
    end
  end

  // Flags follow the value just written to the accumulator.
  always_comb begin
    fz_d = accwr_ctrl ? zero_ctrl     : fz_q;
    fp_d = accwr_ctrl ? positive_ctrl : fp_q;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    shm_d   = shm_q;
    case (state_q)
      StIdle: begin
        if (start_ctrl) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        ir_d    = pm_rdata;
        pc_d    = pc_inc;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = two_byte ? StOperand : StExecute;
      end
      StOperand: begin
        opr_d   = pm_rdata;
        pc_d    = pc_inc;
        state_d = StExecute;
      end
      StExecute: begin
        state_d = StFetch;
        if (!is_alu) begin
          case (opcode)
            OpJmp:   pc_d = opr_q[PcW-1:0];
            OpJz:    if (fz_q) pc_d = opr_q[PcW-1:0];
            OpJp:    if (fp_q) pc_d = opr_q[PcW-1:0];
            OpShm:   shm_d = ir_q[1:0];
            OpHalt:  state_d = StHalt;
            default: ;
          endcase
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Strobes and selects only leave their idle values during EXECUTE.
  always_comb begin
    muxsel_ctrl   = 2'b00;
    imm_ctrl      = 8'h00;
    accwr_ctrl    = 1'b0;
    rfwr_ctrl     = 1'b0;
    outen_ctrl    = 1'b0;
    alusel_ctrl   = 3'b000;
    rfaddr_ctrl   = ir_q[2:0];
    shiftsel_ctrl = shm_q;
    if (state_q == StExecute) begin
      if (is_alu) begin
        alusel_ctrl = ir_q[6:4];
        accwr_ctrl  = 1'b1;
      end else begin
        case (opcode)
          OpLda: begin
            muxsel_ctrl = 2'b01;
            accwr_ctrl  = 1'b1;
          end
          OpSta: rfwr_ctrl = 1'b1;
          OpLdi: begin
            muxsel_ctrl = 2'b11;
            imm_ctrl    = opr_q;
            accwr_ctrl  = 1'b1;
          end
          OpIn: begin
            muxsel_ctrl = 2'b10;
            accwr_ctrl  = 1'b1;
          end
          OpOut:   outen_ctrl = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign halted_ctrl = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-cycle trace table for one program plus
// hand-written sequences for reset, jumps, shift mode, PC wrap and live program writes.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       zero = 1'b0;
  logic       pos = 1'b0;
  logic [1:0] muxsel;
  logic [7:0] imm;
  logic       accwr;
  logic [2:0] rfaddr;
  logic       rfwr;
  logic [2:0] alusel;
  logic [1:0] shiftsel;
  logic       outen;
  logic       halted;
  logic [21:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.PM_DEPTH(32)) dut (
    .clk_ctrl      (clk),
    .rst_ctrl      (rst_n),
    .start_ctrl    (start),
    .prog_we_ctrl  (prog_we),
    .prog_addr_ctrl(prog_addr),
    .prog_data_ctrl(prog_data),
    .zero_ctrl     (zero),
    .positive_ctrl (pos),
    .muxsel_ctrl   (muxsel),
    .imm_ctrl      (imm),
    .accwr_ctrl    (accwr),
    .rfaddr_ctrl   (rfaddr),
    .rfwr_ctrl     (rfwr),
    .alusel_ctrl   (alusel),
    .shiftsel_ctrl (shiftsel),
    .outen_ctrl    (outen),
    .halted_ctrl   (halted)
  );

  always #5 clk = ~clk;

  assign outs = {muxsel, imm, accwr, rfaddr, rfwr, alusel, shiftsel, outen, halted};

  typedef struct {
    logic        start;
    logic        zero;
    logic        pos;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [21:0] o(input logic [1:0] mux, input logic [7:0] im,
                                    input logic acc, input logic [2:0] rfa, input logic rfw,
                                    input logic [2:0] alu, input logic [1:0] sh,
                                    input logic oe, input logic hl);
    return {mux, im, acc, rfa, rfw, alu, sh, oe, hl};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic write_pm(input logic [4:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step(1);
    prog_we   = 1'b0;
  endtask

  task automatic load8(input logic [4:0] base, input logic [63:0] bytes);
    for (int i = 0; i < 8; i++) begin
      write_pm(base + 5'(i), bytes[63-8*i -: 8]);
    end
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // LDI v; Jcc 0x10; LDI 0x55; HALT  with  LDI 0xAA; HALT at 0x10.
  task automatic jump_case(input string name, input logic [7:0] ldi_val, input logic [7:0] jop,
                           input logic z, input logic p, input logic [7:0] exp_imm);
    do_reset();
    load8(5'd0, {8'h18, ldi_val, jop, 8'h10, 8'h18, 8'h55, 8'h50, 8'h00});
    write_pm(5'd16, 8'h18);
    write_pm(5'd17, 8'hAA);
    write_pm(5'd18, 8'h50);
    kick();
    step(3);
    zero = z;
    pos  = p;
    chk({name, "_ldi_accwr"}, accwr, 1'b1);
    step(1);
    // Opposite levels afterwards expose a flag that latches outside accwr.
    zero = !z;
    pos  = !p;
    step(7);
    chk({name, "_imm"}, imm, exp_imm);
    step(4);
    chk({name, "_halted"}, halted, 1'b1);
    zero = 1'b0;
    pos  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic logic [21:0] d0 = o(2'b00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
    automatic logic [21:0] r1 = o(2'b00, 8'h00, 1'b0, 3'd1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0);
    automatic logic [21:0] hl = o(2'b00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b1);

    vecs[0]  = '{1'b0, 1'b0, 1'b0, d0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, d0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, d0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, d0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, o(2'b11, 8'h05, 1'b1, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, d0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, r1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, o(2'b00, 8'h00, 1'b0, 3'd1, 1'b1, 3'd0, 2'b00, 1'b0, 1'b0)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, r1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, d0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, d0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, o(2'b11, 8'h03, 1'b1, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, d0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, r1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, o(2'b00, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0)};
    vecs[15] = '{1'b0, 1'b0, 1'b0, r1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, d0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, o(2'b00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0)};
    vecs[18] = '{1'b0, 1'b0, 1'b0, d0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, d0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, d0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, hl};
    vecs[22] = '{1'b1, 1'b0, 1'b0, hl};
    vecs[23] = '{1'b1, 1'b0, 1'b0, hl};

    step(2);
    chk("reset_outputs", outs, d0);
    rst_n = 1'b1;

    // Reset in the middle of an LDI EXECUTE drops the strobes without a clock edge.
    load8(5'd0, 64'h18_05_11_18_03_81_28_50);
    kick();
    step(3);
    chk("ldi_exec_before_reset", outs,
        o(2'b11, 8'h05, 1'b1, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0));
    #1 rst_n = 1'b0;
    #1 chk("reset_async_outputs", outs, d0);
    #1 rst_n = 1'b1;
    step(2);
    chk("idle_after_reset", outs, d0);

    // Full per-cycle trace: LDI 5; STA R1; LDI 3; ADD R1; OUT; HALT.
    for (int i = 0; i < 24; i++) begin
      start = vecs[i].start;
      zero  = vecs[i].zero;
      pos   = vecs[i].pos;
      step(1);
      chk($sformatf("trace[%0d]", i), outs, vecs[i].exp);
    end
    start = 1'b0;
    zero  = 1'b0;
    pos   = 1'b0;

    jump_case("jz_taken", 8'h00, 8'h38, 1'b1, 1'b0, 8'hAA);
    jump_case("jz_not",   8'h01, 8'h38, 1'b0, 1'b1, 8'h55);
    jump_case("jp_not",   8'h80, 8'h40, 1'b0, 1'b0, 8'h55);
    jump_case("jp_taken", 8'h01, 8'h40, 1'b0, 1'b1, 8'hAA);
    jump_case("jmp",      8'h80, 8'h30, 1'b0, 1'b0, 8'hAA);

    // SHM 01; ADD R1; ALU op 101 on R5; HALT.
    do_reset();
    load8(5'd0, 64'h49_81_D5_50_00_00_00_00);
    kick();
    step(3);
    chk("shm_fetch_shiftsel", shiftsel, 2'b01);
    step(2);
    chk("shm_add_exec", outs, o(2'b00, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0, 2'b01, 1'b0, 1'b0));
    step(3);
    chk("shm_alu5_exec", outs, o(2'b00, 8'h00, 1'b1, 3'd5, 1'b0, 3'd5, 2'b01, 1'b0, 1'b0));
    step(4);
    chk("shm_halted", halted, 1'b1);
    do_reset();
    chk("shm_after_reset", outs, d0);

    // NOP; OUT; JMP 0x1F; LDI at 31 takes its operand from address 0 and returns to 1.
    write_pm(5'd0, 8'h7F);
    write_pm(5'd1, 8'h28);
    write_pm(5'd2, 8'h30);
    write_pm(5'd3, 8'h1F);
    write_pm(5'd31, 8'h18);
    kick();
    step(5);
    chk("wrap_first_out", outen, 1'b1);
    step(8);
    chk("wrap_ldi_exec", outs, o(2'b11, 8'h7F, 1'b1, 3'd0, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0));
    step(3);
    chk("wrap_next_fetch_addr1", outs, o(2'b00, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0));

    // OUT; JMP 0 loop; overwrite pm[0] with HALT during the second fetch of address 0.
    do_reset();
    write_pm(5'd0, 8'h28);
    write_pm(5'd1, 8'h30);
    write_pm(5'd2, 8'h00);
    kick();
    step(7);
    prog_we   = 1'b1;
    prog_addr = 5'd0;
    prog_data = 8'h50;
    step(1);
    prog_we   = 1'b0;
    step(1);
    chk("pmw_old_byte_out", outen, 1'b1);
    step(7);
    chk("pmw_halt_exec_outen", outen, 1'b0);
    chk("pmw_not_yet_halted", halted, 1'b0);
    step(1);
    chk("pmw_new_byte_halted", halted, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
